// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory burst controller.
package dmem_pkg;

   localparam int DW = 16;   // data word width, matches memory dM/m
   localparam int AW = 3;    // memory address width, also burst-length field width

   typedef enum logic [1:0] {
      IDLE,
      ST_BEAT,
      RD_ADDR,
      RD_DATA
   } state_e;

   // len is burst length minus one: 0 -> 1 word, 2**AW-1 -> full sweep
   typedef struct packed {
      logic          wr;
      logic [AW-1:0] addr;
      logic [AW-1:0] len;
   } dmem_cmd_t;

endpackage

// File: rtl/dmem_burst_ctrl_if.sv
// Processor-side handshake bundle: command, store-data and load-data channels.
interface dmem_burst_ctrl_if;
   import dmem_pkg::*;

   logic          cmd_valid;
   logic          cmd_ready;
   dmem_cmd_t     cmd;
   logic          wdata_valid;
   logic          wdata_ready;
   logic [DW-1:0] wdata;
   logic          rdata_valid;
   logic          rdata_ready;
   logic [DW-1:0] rdata;

   // processor / execute side
   modport master (
      output cmd_valid, cmd, wdata_valid, wdata, rdata_ready,
      input  cmd_ready, wdata_ready, rdata_valid, rdata
   );

   // burst controller side
   modport slave (
      input  cmd_valid, cmd, wdata_valid, wdata, rdata_ready,
      output cmd_ready, wdata_ready, rdata_valid, rdata
   );

endinterface

// File: rtl/dmem_addr_gen.sv
// Burst address/beat counter: loads on command accept, wraps address mod 2**AW,
// counts remaining beats and flags the final one.
module dmem_addr_gen
   import dmem_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          load_i,
   input  logic [AW-1:0] addr_i,
   input  logic [AW-1:0] len_i,
   input  logic          step_i,
   output logic [AW-1:0] addr_o,
   output logic [AW-1:0] next_addr_o,
   output logic          last_o
);

   logic [AW-1:0] addr_q, addr_d;
   logic [AW-1:0] cnt_q, cnt_d;

   // next address/count: load wins over step; address wraps naturally at AW bits
   always_comb begin
      addr_d = addr_q;
      cnt_d  = cnt_q;
      if (load_i) begin
         addr_d = addr_i;
         cnt_d  = len_i;
      end else if (step_i) begin
         addr_d = addr_q + 1'b1;
         if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      end
   end

   // address and remaining-beat registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q <= '0;
         cnt_q  <= '0;
      end else begin
         addr_q <= addr_d;
         cnt_q  <= cnt_d;
      end
   end

   assign addr_o      = addr_q;
   assign next_addr_o = addr_q + 1'b1;
   assign last_o      = (cnt_q == '0);

endmodule

// File: rtl/dmem_burst_ctrl.sv
// Initiator for the 8x16 data memory: sequences load/store bursts of 1..8 words
// with address wrap, streams store data in and load data out.
module dmem_burst_ctrl
   import dmem_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   dmem_burst_ctrl_if.slave bus,
   output logic          busy_o,
   output logic [DW-1:0] mem_d_o,
   output logic [AW-1:0] mem_a_o,
   output logic          mem_wr_o,
   input  logic [DW-1:0] mem_q_i
);

   state_e        state_q, state_d;
   logic [DW-1:0] mem_d_q, mem_d_d;
   logic [AW-1:0] mem_a_q, mem_a_d;
   logic          mem_wr_q, mem_wr_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic          rvld_q, rvld_d;

   logic          ld, step, last;
   logic          cmd_rdy, wdata_rdy;
   logic [AW-1:0] addr, next_addr;

   dmem_addr_gen u_addr_gen (
      .clk         (clk),
      .rst         (rst),
      .load_i      (ld),
      .addr_i      (bus.cmd.addr),
      .len_i       (bus.cmd.len),
      .step_i      (step),
      .addr_o      (addr),
      .next_addr_o (next_addr),
      .last_o      (last)
   );

   // next state and memory-side/load-data register updates
   always_comb begin
      state_d   = state_q;
      mem_d_d   = mem_d_q;
      mem_a_d   = mem_a_q;
      mem_wr_d  = 1'b0;            // write strobe only ever lasts one cycle per word
      rdata_d   = rdata_q;
      rvld_d    = rvld_q;
      ld        = 1'b0;
      step      = 1'b0;
      cmd_rdy   = 1'b0;
      wdata_rdy = 1'b0;
      unique case (state_q)
         IDLE: begin
            cmd_rdy = !rst;
            if (bus.cmd_valid) begin
               ld = 1'b1;
               if (bus.cmd.wr) begin
                  state_d = ST_BEAT;
               end else begin
                  // mem_a moves only now, after any in-flight write has committed
                  mem_a_d = bus.cmd.addr;
                  state_d = RD_ADDR;
               end
            end
         end
         ST_BEAT: begin
            wdata_rdy = 1'b1;
            if (bus.wdata_valid) begin
               mem_a_d  = addr;
               mem_d_d  = bus.wdata;
               mem_wr_d = 1'b1;
               step     = 1'b1;
               if (last) state_d = IDLE;
            end
         end
         RD_ADDR: begin
            // memory drove mem_q from mem_a at the preceding negedge
            rdata_d = mem_q_i;
            rvld_d  = 1'b1;
            state_d = RD_DATA;
         end
         RD_DATA: begin
            if (bus.rdata_ready) begin
               rvld_d = 1'b0;
               step   = 1'b1;
               if (last) begin
                  state_d = IDLE;
               end else begin
                  mem_a_d = next_addr;
                  state_d = RD_ADDR;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // state and output registers; async reset also kills a pending write strobe
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         mem_d_q  <= '0;
         mem_a_q  <= '0;
         mem_wr_q <= 1'b0;
         rdata_q  <= '0;
         rvld_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         mem_d_q  <= mem_d_d;
         mem_a_q  <= mem_a_d;
         mem_wr_q <= mem_wr_d;
         rdata_q  <= rdata_d;
         rvld_q   <= rvld_d;
      end
   end

   assign bus.cmd_ready   = cmd_rdy;
   assign bus.wdata_ready = wdata_rdy;
   assign bus.rdata_valid = rvld_q;
   assign bus.rdata       = rdata_q;
   assign busy_o          = (state_q != IDLE);
   assign mem_d_o         = mem_d_q;
   assign mem_a_o         = mem_a_q;
   assign mem_wr_o        = mem_wr_q;

endmodule
